// File: rtl/any1_pkg.sv
// any1_pkg: shared types for the any1 execute pipe.
//   Instruction   - opaque instruction word carried through the pipe
//   Value         - 64-bit register value
//   bf_tag_t      - register/rename tag
//   bf_oc_state_t - operand collector state (IDLE, WAIT, READY)
package any1_pkg;

  localparam int BF_TAGW = 6;
  localparam int NWB_DEF = 2;

  typedef logic [39:0] Instruction;
  typedef logic [63:0] Value;

  typedef logic [BF_TAGW-1:0] bf_tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } bf_oc_state_t;

endpackage

// File: rtl/any1_bf_opsnoop.sv
// any1_bf_opsnoop: one operand slot of the bitfield operand collector.
// Holds a value, its valid bit and its producer tag. Captures the operand
// from the issue port or, while pending, from the first matching writeback bus.
//   clk_i, rst_ni       clock, async active-low reset
//   load_i              issue accepted this cycle (latch issue fields)
//   snoop_en_i          collector is waiting on pending operands
//   iss_v_i/tag/val     issue-side valid, producer tag, value
//   wb_v/tag/val_i      writeback buses (lowest index has priority)
//   v_o, val_o          registered valid and value
//   v_nxt_o             valid bit as it will be after the next edge
module any1_bf_opsnoop
  import any1_pkg::*;
#(
  parameter int NWB  = NWB_DEF,
  parameter int TAGW = BF_TAGW
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_i,
  input  logic                      snoop_en_i,
  input  logic                      iss_v_i,
  input  logic [TAGW-1:0]           iss_tag_i,
  input  Value                      iss_val_i,
  input  logic [NWB-1:0]            wb_v_i,
  input  logic [NWB-1:0][TAGW-1:0]  wb_tag_i,
  input  Value [NWB-1:0]            wb_val_i,
  output logic                      v_o,
  output logic                      v_nxt_o,
  output Value                      val_o
);

  logic [TAGW-1:0] tag_q;
  logic [TAGW-1:0] cmp_tag;
  logic            hit;
  Value            hit_val;
  Value            val_n;

  // On issue the incoming tag is compared directly so a value being written
  // back in the same cycle is bypassed into the slot.
  assign cmp_tag = load_i ? iss_tag_i : tag_q;

  // Priority select: scanning downward lets the lowest matching bus win.
  always_comb begin
    hit     = 1'b0;
    hit_val = '0;
    for (int k = NWB - 1; k >= 0; k--) begin
      if (wb_v_i[k] && (wb_tag_i[k] == cmp_tag)) begin
        hit     = 1'b1;
        hit_val = wb_val_i[k];
      end
    end
  end

  // Next-state for the slot; a match on an already-valid operand is ignored.
  always_comb begin
    v_nxt_o = v_o;
    val_n   = val_o;
    if (load_i) begin
      v_nxt_o = iss_v_i | hit;
      val_n   = (!iss_v_i && hit) ? hit_val : iss_val_i;
    end else if (snoop_en_i && !v_o && hit) begin
      v_nxt_o = 1'b1;
      val_n   = hit_val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_o   <= 1'b0;
      val_o <= '0;
      tag_q <= '0;
    end else begin
      v_o   <= v_nxt_o;
      val_o <= val_n;
      if (load_i) tag_q <= iss_tag_i;
    end
  end

endmodule

// File: rtl/any1_bf_opcollect.sv
// any1_bf_opcollect: single-entry operand collector and result register in
// front of the any1 bitfield unit.
//   clk_i, rst_ni          clock, async active-low reset
//   flush_i                synchronous pipeline flush
//   iss_*                  issue port (inst, dest tag, 4 operands a..d)
//   wb_*                   snooped writeback buses
//   bf_inst_o, bf_[a-d]_o  operand set to the combinational bitfield unit
//   bf_o_i                 result from the bitfield unit
//   out_*                  registered result with valid/ready handshake
module any1_bf_opcollect
  import any1_pkg::*;
#(
  parameter int NWB  = NWB_DEF,
  parameter int TAGW = BF_TAGW
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      iss_v_i,
  output logic                      iss_rdy_o,
  input  Instruction                iss_inst_i,
  input  logic [TAGW-1:0]           iss_tag_i,
  input  logic [3:0]                iss_opv_i,
  input  logic [3:0][TAGW-1:0]      iss_optag_i,
  input  Value [3:0]                iss_opval_i,
  input  logic [NWB-1:0]            wb_v_i,
  input  logic [NWB-1:0][TAGW-1:0]  wb_tag_i,
  input  Value [NWB-1:0]            wb_val_i,
  output Instruction                bf_inst_o,
  output Value                      bf_a_o,
  output Value                      bf_b_o,
  output Value                      bf_c_o,
  output Value                      bf_d_o,
  input  Value                      bf_o_i,
  output logic                      out_v_o,
  input  logic                      out_rdy_i,
  output logic [TAGW-1:0]           out_tag_o,
  output Value                      out_res_o
);

  bf_oc_state_t    state_q, state_n;
  Instruction      inst_q;
  logic [TAGW-1:0] tag_q;
  logic [3:0]      op_v, op_v_n;
  Value [3:0]      op_val;
  logic            capture, accept, snoop_en, all_v;

  // A result is taken when the output register is empty or being drained.
  // Reset gates the ready so nothing is accepted while rst_ni is low.
  assign capture   = (state_q == READY) && (!out_v_o || out_rdy_i);
  assign iss_rdy_o = rst_ni && ((state_q == IDLE) || capture);
  assign accept    = iss_v_i && iss_rdy_o && !flush_i;
  assign snoop_en  = (state_q == WAIT) && !flush_i;
  assign all_v     = &op_v_n;

  for (genvar i = 0; i < 4; i++) begin : g_op
    any1_bf_opsnoop #(.NWB(NWB), .TAGW(TAGW)) u_snoop (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (accept),
      .snoop_en_i (snoop_en),
      .iss_v_i    (iss_opv_i[i]),
      .iss_tag_i  (iss_optag_i[i]),
      .iss_val_i  (iss_opval_i[i]),
      .wb_v_i     (wb_v_i),
      .wb_tag_i   (wb_tag_i),
      .wb_val_i   (wb_val_i),
      .v_o        (op_v[i]),
      .v_nxt_o    (op_v_n[i]),
      .val_o      (op_val[i])
    );
  end

  assign bf_inst_o = inst_q;
  assign bf_a_o    = op_val[0];
  assign bf_b_o    = op_val[1];
  assign bf_c_o    = op_val[2];
  assign bf_d_o    = op_val[3];

  // Next-state logic. A capture in READY may coincide with a new issue,
  // in which case the new entry is routed like an issue from IDLE.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_n = all_v ? READY : WAIT;
      WAIT:    if (all_v) state_n = READY;
      READY: begin
        if (capture) begin
          if (accept) state_n = all_v ? READY : WAIT;
          else        state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      inst_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        inst_q <= iss_inst_i;
        tag_q  <= iss_tag_i;
      end
    end
  end

  // Result register: flush drops any pending result, a capture replaces it,
  // and an accepted handshake without a new capture empties it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_v_o   <= 1'b0;
      out_tag_o <= '0;
      out_res_o <= '0;
    end else if (flush_i) begin
      out_v_o <= 1'b0;
    end else if (capture) begin
      out_v_o   <= 1'b1;
      out_tag_o <= tag_q;
      out_res_o <= bf_o_i;
    end else if (out_rdy_i) begin
      out_v_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_any1_bf_opcollect.sv
// tb_any1_bf_opcollect: directed self-checking bench for any1_bf_opcollect.
// A small stand-in for the bitfield unit drives bf_o_i; expected results are
// queued at issue time and compared when the output handshake completes.
module tb_any1_bf_opcollect;
  import any1_pkg::*;

  typedef struct {
    bf_tag_t tag;
    Value    res;
  } sb_t;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic                        flush_i;
  logic                        iss_v_i;
  logic                        iss_rdy_o;
  Instruction                  iss_inst_i;
  bf_tag_t                     iss_tag_i;
  logic [3:0]                  iss_opv_i;
  logic [3:0][BF_TAGW-1:0]     iss_optag_i;
  Value [3:0]                  iss_opval_i;
  logic [1:0]                  wb_v_i;
  logic [1:0][BF_TAGW-1:0]     wb_tag_i;
  Value [1:0]                  wb_val_i;
  Instruction                  bf_inst_o;
  Value                        bf_a_o, bf_b_o, bf_c_o, bf_d_o;
  Value                        bf_o_i;
  logic                        out_v_o;
  logic                        out_rdy_i;
  bf_tag_t                     out_tag_o;
  Value                        out_res_o;

  int  compared   = 0;
  int  mismatched = 0;
  sb_t sb[$];

  localparam Instruction BFSET = 40'h00_1234_5A6B;
  localparam Instruction BFEXT = 40'h00_0BAD_F00D;

  // Stand-in bitfield unit: rotates each operand differently so a swapped
  // or stale operand shows up in the result.
  function automatic Value bfModel(Instruction i, Value a, Value b, Value c, Value d);
    return a ^ {b[55:0], b[63:56]} ^ {c[47:0], c[63:48]} ^ {d[31:0], d[63:32]} ^ {24'h0, i};
  endfunction

  assign bf_o_i = bfModel(bf_inst_o, bf_a_o, bf_b_o, bf_c_o, bf_d_o);

  always #5 clk_i = ~clk_i;

  any1_bf_opcollect dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .iss_v_i     (iss_v_i),
    .iss_rdy_o   (iss_rdy_o),
    .iss_inst_i  (iss_inst_i),
    .iss_tag_i   (iss_tag_i),
    .iss_opv_i   (iss_opv_i),
    .iss_optag_i (iss_optag_i),
    .iss_opval_i (iss_opval_i),
    .wb_v_i      (wb_v_i),
    .wb_tag_i    (wb_tag_i),
    .wb_val_i    (wb_val_i),
    .bf_inst_o   (bf_inst_o),
    .bf_a_o      (bf_a_o),
    .bf_b_o      (bf_b_o),
    .bf_c_o      (bf_c_o),
    .bf_d_o      (bf_d_o),
    .bf_o_i      (bf_o_i),
    .out_v_o     (out_v_o),
    .out_rdy_i   (out_rdy_i),
    .out_tag_o   (out_tag_o),
    .out_res_o   (out_res_o)
  );

  task automatic checkOutput(input string name, input Value obs, input Value exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input Instruction inst, input bf_tag_t tag, input logic [3:0] opv,
                               input bf_tag_t ta, input bf_tag_t tb, input bf_tag_t tc, input bf_tag_t td,
                               input Value va, input Value vb, input Value vc, input Value vd);
    iss_v_i        = 1'b1;
    iss_inst_i     = inst;
    iss_tag_i      = tag;
    iss_opv_i      = opv;
    iss_optag_i[0] = ta;
    iss_optag_i[1] = tb;
    iss_optag_i[2] = tc;
    iss_optag_i[3] = td;
    iss_opval_i[0] = va;
    iss_opval_i[1] = vb;
    iss_opval_i[2] = vc;
    iss_opval_i[3] = vd;
  endtask

  task automatic driveWb(input logic [1:0] v, input bf_tag_t t0, input bf_tag_t t1,
                         input Value v0, input Value v1);
    wb_v_i      = v;
    wb_tag_i[0] = t0;
    wb_tag_i[1] = t1;
    wb_val_i[0] = v0;
    wb_val_i[1] = v1;
  endtask

  // Every completed output handshake must match the oldest queued result.
  always @(negedge clk_i) begin
    if (rst_ni && out_v_o && out_rdy_i) begin
      compared++;
      assert (sb.size() != 0) else begin
        mismatched++;
        $error("[TB] FAIL sb_unexpected: observed tag %0h expected no output", out_tag_o);
      end
      if (sb.size() != 0) begin
        sb_t e;
        e = sb.pop_front();
        checkOutput("sb_tag", Value'(out_tag_o), Value'(e.tag));
        checkOutput("sb_res", out_res_o, e.res);
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed no finish expected finish before 20000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Value r10, r11;

    rst_ni    = 1'b0;
    flush_i   = 1'b0;
    out_rdy_i = 1'b1;
    applyStimulus('0, '0, 4'b0000, '0, '0, '0, '0, '0, '0, '0, '0);
    iss_v_i   = 1'b0;
    driveWb(2'b00, '0, '0, '0, '0);

    // Reset state
    #3;
    checkOutput("rst_iss_rdy", Value'(iss_rdy_o), 64'd0);
    checkOutput("rst_out_v", Value'(out_v_o), 64'd0);
    checkOutput("rst_out_tag", Value'(out_tag_o), 64'd0);
    checkOutput("rst_out_res", out_res_o, 64'd0);
    #4 rst_ni = 1'b1;
    tick();
    checkOutput("idle_iss_rdy", Value'(iss_rdy_o), 64'd1);

    // All operands valid: result two cycles after issue
    $display("[TB] all-valid BFSET");
    applyStimulus(BFSET, 6'd3, 4'b1111, 6'd0, 6'd0, 6'd0, 6'd0, 64'd0, 64'h77, 64'd4, 64'd3);
    sb.push_back('{6'd3, bfModel(BFSET, 64'd0, 64'h77, 64'd4, 64'd3)});
    tick();
    iss_v_i = 1'b0;
    checkOutput("t1_bf_c", bf_c_o, 64'd4);
    checkOutput("t1_bf_d", bf_d_o, 64'd3);
    checkOutput("t1_out_v_early", Value'(out_v_o), 64'd0);
    tick();
    checkOutput("t1_out_v", Value'(out_v_o), 64'd1);
    checkOutput("t1_out_tag", Value'(out_tag_o), 64'd3);
    tick();
    checkOutput("t1_out_v_drain", Value'(out_v_o), 64'd0);

    // Operand b pending, captured from bus 1
    $display("[TB] pending b via wb1");
    applyStimulus(BFEXT, 6'd6, 4'b1101, 6'd0, 6'd5, 6'd0, 6'd0, 64'h1, 64'hDEAD, 64'h2, 64'h3);
    sb.push_back('{6'd6, bfModel(BFEXT, 64'h1, 64'hAB, 64'h2, 64'h3)});
    tick();
    iss_v_i = 1'b0;
    checkOutput("t2_wait_rdy", Value'(iss_rdy_o), 64'd0);
    tick();
    tick();
    driveWb(2'b10, 6'd0, 6'd5, 64'h0, 64'hAB);
    checkOutput("t2_wait_rdy2", Value'(iss_rdy_o), 64'd0);
    tick();
    driveWb(2'b00, '0, '0, '0, '0);
    checkOutput("t2_bf_b", bf_b_o, 64'hAB);
    checkOutput("t2_out_v_early", Value'(out_v_o), 64'd0);
    tick();
    checkOutput("t2_out_v", Value'(out_v_o), 64'd1);
    tick();

    // Bypass on issue with both buses matching: bus 0 wins
    $display("[TB] issue bypass priority");
    applyStimulus(BFSET, 6'd7, 4'b1011, 6'd0, 6'd0, 6'd9, 6'd0, 64'h5, 64'h6, 64'hFF, 64'h8);
    driveWb(2'b11, 6'd9, 6'd9, 64'h11, 64'h22);
    sb.push_back('{6'd7, bfModel(BFSET, 64'h5, 64'h6, 64'h11, 64'h8)});
    tick();
    iss_v_i = 1'b0;
    driveWb(2'b00, '0, '0, '0, '0);
    checkOutput("t3_bf_c", bf_c_o, 64'h11);
    checkOutput("t3_ready_rdy", Value'(iss_rdy_o), 64'd1);
    tick();
    checkOutput("t3_out_v", Value'(out_v_o), 64'd1);
    tick();

    // Backpressure with a second entry reaching READY
    $display("[TB] backpressure");
    out_rdy_i = 1'b0;
    r10 = bfModel(BFSET, 64'h10, 64'h20, 64'h30, 64'h40);
    r11 = bfModel(BFEXT, 64'h11, 64'h21, 64'h31, 64'h41);
    applyStimulus(BFSET, 6'd10, 4'b1111, '0, '0, '0, '0, 64'h10, 64'h20, 64'h30, 64'h40);
    sb.push_back('{6'd10, r10});
    tick();
    applyStimulus(BFEXT, 6'd11, 4'b1111, '0, '0, '0, '0, 64'h11, 64'h21, 64'h31, 64'h41);
    sb.push_back('{6'd11, r11});
    tick();
    iss_v_i = 1'b0;
    checkOutput("t4_rdy_blocked", Value'(iss_rdy_o), 64'd0);
    checkOutput("t4_tag_first", Value'(out_tag_o), 64'd10);
    tick();
    checkOutput("t4_hold_v", Value'(out_v_o), 64'd1);
    checkOutput("t4_hold_tag", Value'(out_tag_o), 64'd10);
    checkOutput("t4_hold_res", out_res_o, r10);
    checkOutput("t4_hold_rdy", Value'(iss_rdy_o), 64'd0);
    out_rdy_i = 1'b1;
    #1;
    checkOutput("t4_rdy_release", Value'(iss_rdy_o), 64'd1);
    tick();
    checkOutput("t4_tag_second", Value'(out_tag_o), 64'd11);
    checkOutput("t4_res_second", out_res_o, r11);
    tick();
    checkOutput("t4_drain", Value'(out_v_o), 64'd0);

    // Flush in WAIT, then a late match must not resurrect the entry
    $display("[TB] flush in wait");
    applyStimulus(BFSET, 6'd20, 4'b1110, 6'd21, '0, '0, '0, 64'h0, 64'h1, 64'h2, 64'h3);
    tick();
    iss_v_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checkOutput("t5_flush_rdy", Value'(iss_rdy_o), 64'd1);
    driveWb(2'b01, 6'd21, 6'd0, 64'h99, 64'h0);
    tick();
    driveWb(2'b00, '0, '0, '0, '0);
    tick();
    checkOutput("t5_no_out", Value'(out_v_o), 64'd0);

    // Flush coinciding with a capture
    $display("[TB] flush on capture");
    applyStimulus(BFSET, 6'd22, 4'b1111, '0, '0, '0, '0, 64'h4, 64'h5, 64'h6, 64'h7);
    tick();
    iss_v_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checkOutput("t5b_out_v", Value'(out_v_o), 64'd0);
    checkOutput("t5b_rdy", Value'(iss_rdy_o), 64'd1);
    tick();
    checkOutput("t5b_out_v2", Value'(out_v_o), 64'd0);

    // Asynchronous reset mid-WAIT with a result pending
    $display("[TB] reset mid-wait");
    out_rdy_i = 1'b0;
    applyStimulus(BFSET, 6'd23, 4'b1111, '0, '0, '0, '0, 64'h8, 64'h9, 64'hA, 64'hB);
    sb.push_back('{6'd23, bfModel(BFSET, 64'h8, 64'h9, 64'hA, 64'hB)});
    tick();
    applyStimulus(BFEXT, 6'd24, 4'b0111, '0, '0, '0, 6'd30, 64'h1, 64'h2, 64'h3, 64'h0);
    tick();
    iss_v_i = 1'b0;
    checkOutput("t6_pending", Value'(out_v_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("t6_rst_out_v", Value'(out_v_o), 64'd0);
    checkOutput("t6_rst_rdy", Value'(iss_rdy_o), 64'd0);
    sb.delete();
    driveWb(2'b01, 6'd30, 6'd0, 64'h55, 64'h0);
    tick();
    driveWb(2'b00, '0, '0, '0, '0);
    rst_ni    = 1'b1;
    out_rdy_i = 1'b1;
    tick();
    checkOutput("t6_rel_rdy", Value'(iss_rdy_o), 64'd1);
    checkOutput("t6_rel_out_v", Value'(out_v_o), 64'd0);
    applyStimulus(BFSET, 6'd25, 4'b1111, '0, '0, '0, '0, 64'hC, 64'hD, 64'hE, 64'hF);
    sb.push_back('{6'd25, bfModel(BFSET, 64'hC, 64'hD, 64'hE, 64'hF)});
    tick();
    iss_v_i = 1'b0;
    tick();
    checkOutput("t6_fresh_v", Value'(out_v_o), 64'd1);
    checkOutput("t6_fresh_tag", Value'(out_tag_o), 64'd25);
    tick();

    checkOutput("sb_empty", Value'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
